// File: rtl/gf_sqscl_arb_pkg.sv
// Shared constants and pipeline stage record for the GF(2^4) square-scale arbiter.
package gf_sqscl_arb_pkg;

  localparam int unsigned NREQ = 4;
  localparam int unsigned ID_W = 2;

  typedef struct packed {
    logic            valid;
    logic [3:0]      data;
    logic [ID_W-1:0] id;
  } stage_t;

endpackage

// File: rtl/gf_sqscl_unit.sv
// Combinational GF(2^4) square-scale map: A = {a, b} -> {swap(a^b), b1^b0, b0}.
module gf_sqscl_unit (
  input  logic [3:0] a_i,
  output logic [3:0] q_o
);

  logic [1:0] hi;
  logic [1:0] lo;
  logic [1:0] x;

  assign hi  = a_i[3:2];
  assign lo  = a_i[1:0];
  assign x   = hi ^ lo;
  assign q_o = {x[0], x[1], lo[1] ^ lo[0], lo[0]};

endmodule

// File: rtl/gf_sqscl_arb.sv
// Four-requester round-robin front end feeding one shared square-scale unit via a 2-stage pipeline.
// Optional macro GF_SQSCL_PRIO_EN gives requester 0 absolute priority over the rotation.
module gf_sqscl_arb #(
  parameter int unsigned NREQ = gf_sqscl_arb_pkg::NREQ
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NREQ-1:0]                 req_valid,
  input  logic [4*NREQ-1:0]               req_data,
  output logic [NREQ-1:0]                 req_ready,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [3:0]                      rsp_data,
  output logic [gf_sqscl_arb_pkg::ID_W-1:0] rsp_id
);

  import gf_sqscl_arb_pkg::*;

  stage_t          s1_q, s1_d;
  stage_t          s2_q, s2_d;
  logic [ID_W-1:0] ptr_q, ptr_d;

  logic [3:0]      nib [NREQ];
  logic [3:0]      unit_q;
  logic [NREQ-1:0] rr_valid;
  logic [ID_W-1:0] gnt_idx;
  logic [ID_W-1:0] idx;
  logic            gnt_any;
  logic            prio_hit;
  logic            s2_adv;
  logic            s1_free;
  logic            take;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_nib
    assign nib[gi] = req_data[4*gi +: 4];
  end

  gf_sqscl_unit u_unit (
    .a_i (s1_q.data),
    .q_o (unit_q)
  );

  // Walk downward so the requester closest to ptr is the one left in gnt_idx.
  always_comb begin
    rr_valid = req_valid;
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    idx      = '0;
    prio_hit = 1'b0;
`ifdef GF_SQSCL_PRIO_EN
    rr_valid[0] = 1'b0;
`endif
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = ptr_q + ID_W'(k);
      if (rr_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = idx;
      end
    end
`ifdef GF_SQSCL_PRIO_EN
    if (req_valid[0]) begin
      gnt_any  = 1'b1;
      gnt_idx  = '0;
      prio_hit = 1'b1;
    end
`endif
  end

  always_comb begin
    s2_adv    = !s2_q.valid || rsp_ready;
    s1_free   = !s1_q.valid || s2_adv;
    take      = s1_free && gnt_any && !rst;
    req_ready = take ? (NREQ'(1) << gnt_idx) : '0;

    s2_d = s2_q;
    if (s2_adv) begin
      s2_d = '{valid: s1_q.valid, data: unit_q, id: s1_q.id};
    end

    s1_d = s1_q;
    if (s1_free) begin
      s1_d = '{valid: take, data: nib[gnt_idx], id: gnt_idx};
    end

    ptr_d = ptr_q;
    if (take && !prio_hit) begin
      ptr_d = gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q  <= '0;
      s2_q  <= '0;
      ptr_q <= '0;
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      ptr_q <= ptr_d;
    end
  end

  assign rsp_valid = s2_q.valid;
  assign rsp_data  = s2_q.data;
  assign rsp_id    = s2_q.id;

endmodule

// File: tb/tb_gf_sqscl_arb.sv
// Directed self-checking bench for gf_sqscl_arb; inputs change and outputs are sampled at negedge.
module tb_gf_sqscl_arb;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [15:0] req_data;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [3:0]  rsp_data;
  logic [1:0]  rsp_id;

  int compared   = 0;
  int mismatched = 0;

  gf_sqscl_arb dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 4'b1111; req_data = 16'h3210; rsp_ready = 1'b1;
    tick(); tick(); #1;
    compared++; if (rsp_valid !== 1'b0) begin mismatched++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    compared++; if (rsp_data !== 4'h0) begin mismatched++; $display("FAIL reset_rsp_data got=%h exp=0", rsp_data); end
    compared++; if (rsp_id !== 2'd0) begin mismatched++; $display("FAIL reset_rsp_id got=%0d exp=0", rsp_id); end
    compared++; if (req_ready !== 4'b0000) begin mismatched++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
    req_valid = 4'b0000;
    tick();
    rst = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_single();
    req_valid = 4'b0001; req_data = 16'h0001; rsp_ready = 1'b1;
    #1;
    compared++; if (req_ready !== 4'b0001) begin mismatched++; $display("FAIL single_grant got=%b exp=0001", req_ready); end
    tick();
    req_valid = 4'b0000; #1;
    compared++; if (rsp_valid !== 1'b0) begin mismatched++; $display("FAIL single_early got=%b exp=0", rsp_valid); end
    tick(); #1;
    compared++; if ({rsp_valid, rsp_data, rsp_id} !== {1'b1, 4'hB, 2'd0}) begin mismatched++; $display("FAIL single_rsp got=v%b d%h id%0d exp=v1 dB id0", rsp_valid, rsp_data, rsp_id); end
    tick(); #1;
    compared++; if (rsp_valid !== 1'b0) begin mismatched++; $display("FAIL single_after got=%b exp=0", rsp_valid); end
    $display("test_single done");
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_d [3];
    exp_d[0] = 4'h8; exp_d[1] = 4'h1; exp_d[2] = 4'h0;
    req_valid = 4'b0100; req_data = 16'h0400; rsp_ready = 1'b1;
    #1;
    compared++; if (req_ready !== 4'b0100) begin mismatched++; $display("FAIL b2b_grant got=%b exp=0100", req_ready); end
    tick(); req_data = 16'h0F00; #1;
    compared++; if (req_ready !== 4'b0100) begin mismatched++; $display("FAIL b2b_grant2 got=%b exp=0100", req_ready); end
    tick(); req_data = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      #1;
      compared++; if ({rsp_valid, rsp_data, rsp_id} !== {1'b1, exp_d[i], 2'd2}) begin mismatched++; $display("FAIL b2b_rsp%0d got=v%b d%h id%0d exp=v1 d%h id2", i, rsp_valid, rsp_data, rsp_id, exp_d[i]); end
      tick();
      if (i == 0) req_valid = 4'b0000;
    end
    #1;
    compared++; if (rsp_valid !== 1'b0) begin mismatched++; $display("FAIL b2b_after got=%b exp=0", rsp_valid); end
    $display("test_back_to_back done");
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_d [4];
    exp_d[0] = 4'h0; exp_d[1] = 4'hB; exp_d[2] = 4'h6; exp_d[3] = 4'hD;
    do_reset();
    req_valid = 4'b1111; req_data = 16'h3210; rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 5) req_valid = 4'b0000;
      #1;
      if (i < 5) begin
        compared++; if (req_ready !== (4'b0001 << (i % 4))) begin mismatched++; $display("FAIL rr_grant%0d got=%b exp=%b", i, req_ready, 4'b0001 << (i % 4)); end
      end
      if (i >= 2 && i < 7) begin
        compared++; if ({rsp_valid, rsp_data, rsp_id} !== {1'b1, exp_d[(i-2)%4], 2'((i-2)%4)}) begin mismatched++; $display("FAIL rr_rsp%0d got=v%b d%h id%0d exp=v1 d%h id%0d", i, rsp_valid, rsp_data, rsp_id, exp_d[(i-2)%4], (i-2)%4); end
      end
      if (i == 7) begin
        compared++; if (rsp_valid !== 1'b0) begin mismatched++; $display("FAIL rr_after got=%b exp=0", rsp_valid); end
      end
      tick();
    end
    $display("test_round_robin done");
  endtask

  task automatic test_stall();
    do_reset();
    rsp_ready = 1'b0; req_valid = 4'b0001; req_data = 16'h0001;
    #1;
    compared++; if (req_ready !== 4'b0001) begin mismatched++; $display("FAIL stall_grant0 got=%b exp=0001", req_ready); end
    tick(); req_data = 16'h0004; #1;
    compared++; if (req_ready !== 4'b0001) begin mismatched++; $display("FAIL stall_grant1 got=%b exp=0001", req_ready); end
    tick();
    for (int i = 0; i < 3; i++) begin
      req_data = 16'h000F ^ 16'(i);
      #1;
      compared++; if (req_ready !== 4'b0000) begin mismatched++; $display("FAIL stall_ready%0d got=%b exp=0000", i, req_ready); end
      compared++; if ({rsp_valid, rsp_data, rsp_id} !== {1'b1, 4'hB, 2'd0}) begin mismatched++; $display("FAIL stall_hold%0d got=v%b d%h id%0d exp=v1 dB id0", i, rsp_valid, rsp_data, rsp_id); end
      tick();
    end
    req_valid = 4'b0000; rsp_ready = 1'b1; #1;
    compared++; if ({rsp_valid, rsp_data} !== {1'b1, 4'hB}) begin mismatched++; $display("FAIL drain0 got=v%b d%h exp=v1 dB", rsp_valid, rsp_data); end
    tick(); #1;
    compared++; if ({rsp_valid, rsp_data, rsp_id} !== {1'b1, 4'h8, 2'd0}) begin mismatched++; $display("FAIL drain1 got=v%b d%h id%0d exp=v1 d8 id0", rsp_valid, rsp_data, rsp_id); end
    tick(); #1;
    compared++; if (rsp_valid !== 1'b0) begin mismatched++; $display("FAIL drain_end got=%b exp=0", rsp_valid); end
    $display("test_stall done");
  endtask

  task automatic test_reset_midflight();
    do_reset();
    rsp_ready = 1'b0; req_valid = 4'b1111; req_data = 16'h3210;
    tick(); tick(); #1;
    compared++; if ({rsp_valid, rsp_id, req_ready} !== {1'b1, 2'd0, 4'b0000}) begin mismatched++; $display("FAIL mid_full got=v%b id%0d rdy%b exp=v1 id0 rdy0000", rsp_valid, rsp_id, req_ready); end
    rst = 1'b1; req_valid = 4'b1110; req_data = 16'h0050; #1;
    compared++; if (req_ready !== 4'b0000) begin mismatched++; $display("FAIL mid_rst_ready got=%b exp=0000", req_ready); end
    tick(); rst = 1'b0; rsp_ready = 1'b1; #1;
    compared++; if (rsp_valid !== 1'b0) begin mismatched++; $display("FAIL mid_rsp_cleared got=%b exp=0", rsp_valid); end
    compared++; if (req_ready !== 4'b0010) begin mismatched++; $display("FAIL mid_lowest_grant got=%b exp=0010", req_ready); end
    tick(); req_valid = 4'b0000; #1;
    compared++; if (rsp_valid !== 1'b0) begin mismatched++; $display("FAIL mid_no_stale got=%b exp=0", rsp_valid); end
    tick(); #1;
    compared++; if ({rsp_valid, rsp_data, rsp_id} !== {1'b1, 4'h3, 2'd1}) begin mismatched++; $display("FAIL mid_rsp got=v%b d%h id%0d exp=v1 d3 id1", rsp_valid, rsp_data, rsp_id); end
    tick(); #1;
    compared++; if (rsp_valid !== 1'b0) begin mismatched++; $display("FAIL mid_after got=%b exp=0", rsp_valid); end
    $display("test_reset_midflight done");
  endtask

`ifdef GF_SQSCL_PRIO_EN
  task automatic test_prio();
    logic [3:0] exp_g [4];
    exp_g[0] = 4'b0010; exp_g[1] = 4'b0100; exp_g[2] = 4'b1000; exp_g[3] = 4'b0010;
    do_reset();
    rsp_ready = 1'b1; req_valid = 4'b1111; req_data = 16'h3210;
    for (int i = 0; i < 3; i++) begin
      #1;
      compared++; if (req_ready !== 4'b0001) begin mismatched++; $display("FAIL prio_r0_%0d got=%b exp=0001", i, req_ready); end
      tick();
    end
    req_valid = 4'b1110;
    for (int i = 0; i < 4; i++) begin
      #1;
      compared++; if (req_ready !== exp_g[i]) begin mismatched++; $display("FAIL prio_rot%0d got=%b exp=%b", i, req_ready, exp_g[i]); end
      tick();
    end
    req_valid = 4'b0000;
    tick(); tick();
    $display("test_prio done");
  endtask
`endif

  initial begin
    rst = 1'b1; req_valid = '0; req_data = '0; rsp_ready = 1'b1;
    tick();
    test_reset();
    test_single();
    test_back_to_back();
    test_round_robin();
    test_stall();
    test_reset_midflight();
`ifdef GF_SQSCL_PRIO_EN
    test_prio();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/gf_sqscl_arb.md
GF_SQSCL_ARB -- requirements
Module: gf_sqscl_arb

Interface
REQ-001 SHALL have parameter: NREQ, 4, number of requesters (fixed at 4; other values unsupported).
REQ-002 SHALL have ports, one per line:
  clk  input  1  clock, all state on rising edge
  rst  input  1  reset, synchronous, active-high
  req_valid  input  4  per-requester operand valid
  req_data  input  16  operand for requester i in bits [4i+3:4i]
  req_ready  output  4  per-requester accept; one-hot or zero
  rsp_valid  output  1  result valid
  rsp_ready  input  1  downstream accept
  rsp_data  output  4  GF(2^4) square-scale result
  rsp_id  output  2  index of requester that issued the operand
REQ-003 SHALL have one clock; reset is synchronous and active-high.

Function
REQ-004 SHALL compute, for operand A = {a[1:0], b[1:0]}: Q[3:2] = swap(a^b), Q[1:0] = {b[1]^b[0], b[0]}, where swap(x) = {x[0], x[1]}.
REQ-005 SHALL hold one shared compute unit and a two-stage pipeline:
  - S1 holds the granted operand and id.
  - S2 holds the result and id.
  - Each stage has a valid flag.
REQ-006 SHALL drive rsp_valid = S2 valid, rsp_data = S2 result and rsp_id = S2 id, all directly from registers.
REQ-007 SHALL load S2 from S1 when S2 is empty or rsp_ready=1; a handshake is rsp_valid & rsp_ready.
REQ-008 SHALL consider S1 free when S1 is empty or S1 is advancing into S2 this cycle.
REQ-009 SHALL assert exactly one req_ready bit, for the granted requester, when S1 is free and any req_valid bit is set; otherwise req_ready = 0.
REQ-010 SHALL arbitrate round-robin:
  - Search starts at pointer ptr and proceeds ptr, ptr+1, ... mod 4.
  - The first valid requester is granted.
  - On each grant handshake, ptr becomes granted index + 1 (mod 4), so 3 wraps to 0.
REQ-011 SHALL give latency 2 cycles from a req handshake to rsp_valid when unstalled, and sustain 1 result per cycle.
REQ-012 SHALL hold S2 contents stable while rsp_valid=1 and rsp_ready=0.
REQ-013 SHALL stall upstream when both stages are full and rsp_ready=0: req_ready = 0, and S1 is unchanged.
REQ-014 SHALL accept a new grant in the same cycle S1 advances (simultaneous drain and fill); there is no bubble.
REQ-015 SHALL NOT change ptr when no grant handshake occurs.
REQ-016 SHALL NOT require req_data to remain stable when req_ready=0.

Reset
REQ-017 SHALL, on rst=1 at a clock edge, clear the S1 and S2 valid flags and set ptr=0.
REQ-018 SHALL hold rsp_valid=0, rsp_data=0, rsp_id=0 and req_ready=0 while rst=1.
REQ-019 SHALL discard in-flight operands and results when reset is asserted mid-operation; no response is produced for them.

Configuration
REQ-020 SHALL support macro GF_SQSCL_PRIO_EN:
  - Defined: requester 0 wins whenever req_valid[0]=1. Otherwise the round-robin order of REQ-010 applies among requesters 1-3, and ptr does not advance on requester-0 grants.
  - Undefined: pure round-robin per REQ-010.

Structure
REQ-021 SHALL place in a shared package:
  - NREQ and the id width constant (2).
  - The stage record typedef {valid, data[3:0], id[1:0]}.
REQ-022 SHALL implement the REQ-004 mapping as combinational sub-module gf_sqscl_unit (4-bit in, 4-bit out), instantiated once between S1 and S2.

Verification
REQ-023 SHALL cover: req_valid=0001, req_data nibble0=0x1, rsp_ready=1 -> rsp_valid two cycles after the handshake with rsp_data=0xB, rsp_id=0.
REQ-024 SHALL cover: operands 0x4, 0xF, 0x0 from requester 2 back-to-back -> rsp_data 0x8, 0x1, 0x0, id=2, on consecutive cycles.
REQ-025 SHALL cover: all four req_valid held high after reset, rsp_ready=1 -> grant order 0,1,2,3,0 (wrap), responses in the same order.
REQ-026 SHALL cover: rsp_ready=0 with continuous requests -> two responses buffered, req_ready=0 from the third cycle, rsp_data stable. Then rsp_ready=1 -> drain in order with no loss or duplication.
REQ-027 SHALL cover: rst=1 pulsed for one cycle with both stages full -> rsp_valid=0 next cycle, ptr=0, and the next grant goes to the lowest valid index.
REQ-028 SHALL cover, with GF_SQSCL_PRIO_EN: req_valid=1111 continuous -> requester 0 granted every cycle. Drop req_valid[0] -> grants rotate 1,2,3,1.
